// File: rtl/pixel_valid_if.sv
// Pixel stream bundle without backpressure.
// pixel : 24-bit pixel, packed {red, green, blue}, 8 bits each
// valid : pixel is present this cycle
interface pixel_valid_if;
  logic [23:0] pixel;
  logic        valid;

  modport master (output pixel, output valid);
  modport slave  (input  pixel, input  valid);
endinterface

// File: rtl/median_output_framer.sv
// Output framer for the median filter. Buffers the filtered pixel stream in a
// small first-word-fall-through FIFO, tags each beat with sof/eol/eof and
// re-emits it on a valid/ready port. Pulses done_o once the frame has drained,
// counts completed frames and flags dropped input pixels.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           arms the block for one frame (honoured in IDLE only)
//   pixel_valid_if_i  filtered pixel stream in (no backpressure)
//   m_pixel_o/m_valid_o/m_ready_i  output beat handshake
//   m_sof_o/m_eol_o/m_eof_o        tags of the current output beat
//   done_o            one-cycle pulse when the frame has fully drained
//   overflow_o        sticky: an input pixel was dropped this frame
//   frame_cnt_o       completed-frame count, wraps at 2^16
//
// state  | meaning
// IDLE   | waiting for start_i; input pixels ignored
// ACTIVE | counting and buffering input pixels of the frame
// DRAIN  | frame fully counted; waiting for the FIFO to empty
module median_output_framer #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  pixel_valid_if.slave        pixel_valid_if_i,
  output logic [23:0]         m_pixel_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                m_sof_o,
  output logic                m_eol_o,
  output logic                m_eof_o,
  output logic                done_o,
  output logic                overflow_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int XW = (IMAGE_LEN - 1 > 1) ? $clog2(IMAGE_LEN - 1) : 1;
  localparam int YW = (IMAGE_HEIGHT - 1 > 1) ? $clog2(IMAGE_HEIGHT - 1) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [XW-1:0] X_LAST  = XW'(IMAGE_LEN - 2);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMAGE_HEIGHT - 2);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [26:0]   mem [FIFO_DEPTH];
  logic [26:0]   head;

  logic empty, full, pop, push, drop, in_pixel;
  logic x_last, y_last;
  logic tag_sof, tag_eol, tag_eof;
  logic clear_frame;
  logic done;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign pop      = !empty && m_ready_i;
  assign in_pixel = (state_q == ACTIVE) && pixel_valid_if_i.valid;
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign push     = in_pixel && (!full || pop);
  assign drop     = in_pixel && full && !pop;

  assign x_last  = (x_q == X_LAST);
  assign y_last  = (y_q == Y_LAST);
  assign tag_sof = (x_q == '0) && (y_q == '0);
  assign tag_eol = x_last;
  assign tag_eof = x_last && y_last;

  always_comb begin
    state_d     = state_q;
    clear_frame = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = ACTIVE;
          clear_frame = 1'b1;
        end
      end
      ACTIVE: begin
        // Dropped pixels still count, so a dropped eof pixel ends the frame.
        if (in_pixel && x_last && y_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_frame) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_pixel) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_frame) overflow_o <= 1'b0;
    else if (drop)          overflow_o <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       frame_cnt_o <= '0;
    else if (done) frame_cnt_o <= frame_cnt_o + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted in count_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {tag_sof, tag_eol, tag_eof, pixel_valid_if_i.pixel};
  end

  assign head = mem[rd_ptr_q];

  // Gate the head with empty so stale storage never reaches the outputs.
  assign m_valid_o = !empty;
  assign m_pixel_o = empty ? 24'd0 : head[23:0];
  assign m_sof_o   = !empty && head[26];
  assign m_eol_o   = !empty && head[25];
  assign m_eof_o   = !empty && head[24];
  assign done_o    = done;

endmodule

// File: tb/tb_median_output_framer.sv
module tb_median_output_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        m_ready;
  logic [23:0] m_pixel;
  logic        m_valid, m_sof, m_eol, m_eof, done, overflow;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  pixel_valid_if pv_if ();

  median_output_framer #(
    .IMAGE_LEN   (4),
    .IMAGE_HEIGHT(3),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .pixel_valid_if_i(pv_if),
    .m_pixel_o       (m_pixel),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_sof_o         (m_sof),
    .m_eol_o         (m_eol),
    .m_eof_o         (m_eof),
    .done_o          (done),
    .overflow_o      (overflow),
    .frame_cnt_o     (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [23:0] pix,
                          input logic sof, input logic eol, input logic eof);
    chk({tag, ".valid"}, m_valid, 1);
    chk({tag, ".pixel"}, m_pixel, pix);
    chk({tag, ".sof"},   m_sof,   sof);
    chk({tag, ".eol"},   m_eol,   eol);
    chk({tag, ".eof"},   m_eof,   eof);
  endtask

  // One full 3x2 frame with m_ready held high; start_at pulses start_i
  // together with that pixel to prove it is ignored while ACTIVE.
  task automatic run_frame(input string tag, input logic [23:0] base,
                           input int start_at, input logic [15:0] exp_cnt);
    m_ready     = 1'b1;
    start       = 1'b1;
    pv_if.valid = 1'b0;
    cyc();
    for (int k = 1; k <= 6; k++) begin
      start       = (k == start_at);
      pv_if.valid = 1'b1;
      pv_if.pixel = base + 24'(k - 1);
      cyc();
      chk_beat($sformatf("%s.beat%0d", tag, k), base + 24'(k - 1),
               k == 1, (k % 3) == 0, k == 6);
      chk({tag, ".done_early"}, done, 0);
    end
    start       = 1'b0;
    pv_if.valid = 1'b0;
    cyc();
    chk({tag, ".done"},       done,    1);
    chk({tag, ".empty"},      m_valid, 0);
    cyc();
    chk({tag, ".done_once"},  done,      0);
    chk({tag, ".frame_cnt"},  frame_cnt, exp_cnt);
    chk({tag, ".overflow"},   overflow,  0);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    start       = 1'b0;
    pv_if.valid = 1'b0;
    pv_if.pixel = '0;
    m_ready     = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start       = 1'($urandom);
      pv_if.valid = 1'($urandom);
      pv_if.pixel = 24'($urandom);
      m_ready     = 1'($urandom);
      cyc();
    end
    chk("rst.valid",     m_valid,   0);
    chk("rst.pixel",     m_pixel,   0);
    chk("rst.sof",       m_sof,     0);
    chk("rst.eol",       m_eol,     0);
    chk("rst.eof",       m_eof,     0);
    chk("rst.done",      done,      0);
    chk("rst.overflow",  overflow,  0);
    chk("rst.frame_cnt", frame_cnt, 0);

    // Inputs in IDLE without start are ignored
    rst         = 1'b0;
    start       = 1'b0;
    m_ready     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv_if.valid = 1'b1;
      pv_if.pixel = 24'($urandom);
      cyc();
      chk("idle.valid", m_valid, 0);
      chk("idle.count", dut.count_q, 0);
    end

    // Nominal frame
    run_frame("nom", 24'h000001, 0, 16'd1);

    // Backpressure for the whole frame: 4 buffered, 2 dropped
    do_reset();
    m_ready     = 1'b0;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      pv_if.valid = 1'b1;
      pv_if.pixel = 24'(k);
      cyc();
    end
    pv_if.valid = 1'b0;
    chk("bp.overflow", overflow,    1);
    chk("bp.state",    dut.state_q, 2);
    chk("bp.count",    dut.count_q, 4);
    chk("bp.done",     done,        0);
    cyc();
    chk("bp.hold_done", done, 0);
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk_beat($sformatf("bp.beat%0d", k), 24'(k), k == 1, k == 3, 1'b0);
      cyc();
    end
    chk("bp.done_pulse", done,      1);
    chk("bp.drained",    m_valid,   0);
    cyc();
    chk("bp.done_once",  done,      0);
    chk("bp.frame_cnt",  frame_cnt, 1);
    chk("bp.ovf_sticky", overflow,  1);

    // Stall hold on beat 2, then full FIFO with a simultaneous pop
    do_reset();
    m_ready = 1'b1;
    start   = 1'b1;
    cyc();
    start       = 1'b0;
    pv_if.valid = 1'b1;
    pv_if.pixel = 24'h000001;
    cyc();
    chk_beat("st.beat1", 24'h000001, 1, 0, 0);
    pv_if.pixel = 24'h000002;
    cyc();
    chk_beat("st.beat2", 24'h000002, 0, 0, 0);
    m_ready = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      pv_if.pixel = 24'(k);
      cyc();
      chk_beat($sformatf("st.hold%0d", k - 2), 24'h000002, 0, 0, 0);
    end
    chk("st.full_count", dut.count_q, 4);
    m_ready     = 1'b1;
    pv_if.pixel = 24'h000006;
    cyc();
    chk("fp.count",    dut.count_q, 4);
    chk("fp.overflow", overflow,    0);
    chk("fp.state",    dut.state_q, 2);
    pv_if.valid = 1'b0;
    chk_beat("st.beat3", 24'h000003, 0, 1, 0);
    cyc();
    chk_beat("st.beat4", 24'h000004, 0, 0, 0);
    cyc();
    chk_beat("st.beat5", 24'h000005, 0, 0, 0);
    cyc();
    chk_beat("st.beat6", 24'h000006, 0, 1, 1);
    cyc();
    chk("st.done",      done,      1);
    cyc();
    chk("st.frame_cnt", frame_cnt, 1);
    chk("st.overflow",  overflow,  0);

    // start_i pulsed mid-frame is ignored; frame still ends on pixel 6
    run_frame("midstart", 24'h000A01, 3, 16'd2);

    // Reset after pixel 3 discards the FIFO
    m_ready = 1'b0;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      pv_if.valid = 1'b1;
      pv_if.pixel = 24'h000B00 + 24'(k);
      cyc();
    end
    chk("mr.pre_count", dut.count_q, 3);
    pv_if.valid = 1'b0;
    rst         = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr.valid",     m_valid,     0);
    chk("mr.count",     dut.count_q, 0);
    chk("mr.frame_cnt", frame_cnt,   0);
    chk("mr.state",     dut.state_q, 0);

    // Clean frame afterwards
    run_frame("clean", 24'h000C01, 0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
